// File: rtl/vending_machine_change.sv
// Newspaper vending FSM: debounced coin/cancel/restock inputs, credit
// accumulation, timed dispense LED, paced change/refund pulses, stock count.
// Ports: clk, reset (async, high); coin[2:0], cancel, restock (raw inputs);
//   newspaper, credit, change_pulse, coin_reject, stock, sold_out (outputs).
module vending_machine_change #(
  parameter int PRICE           = 15,
  parameter int COIN_UNIT       = 5,
  parameter int COIN0_VAL       = 5,
  parameter int COIN1_VAL       = 10,
  parameter int COIN2_VAL       = 15,
  parameter int MAX_CREDIT      = 30,
  parameter int AMT_W           = 6,
  parameter int STOCK_INIT      = 8,
  parameter int STOCK_W         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DISPLAY_CYCLES  = 200_000_000,
  parameter int CHANGE_GAP      = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         coin,
  input  logic               cancel,
  input  logic               restock,
  output logic               newspaper,
  output logic [AMT_W-1:0]   credit,
  output logic               change_pulse,
  output logic               coin_reject,
  output logic [STOCK_W-1:0] stock,
  output logic               sold_out
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DISP_W = $clog2(DISPLAY_CYCLES + 1);
  localparam int GAP_W  = $clog2(CHANGE_GAP + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCUM   = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_CHANGE  = 3'd3;
  localparam logic [2:0] S_REFUND  = 3'd4;
  localparam logic [2:0] S_SOLDOUT = 3'd5;

  localparam logic [AMT_W-1:0] L_PRICE = AMT_W'(PRICE);
  localparam logic [AMT_W-1:0] L_UNIT  = AMT_W'(COIN_UNIT);
  localparam logic [AMT_W-1:0] L_C0    = AMT_W'(COIN0_VAL);
  localparam logic [AMT_W-1:0] L_C1    = AMT_W'(COIN1_VAL);
  localparam logic [AMT_W-1:0] L_C2    = AMT_W'(COIN2_VAL);
  localparam logic [AMT_W:0]   L_MAX   = (AMT_W+1)'(MAX_CREDIT);

  // bit 0..2 coins, bit 3 cancel, bit 4 restock
  logic [4:0]      w_raw;
  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      r_stable;
  logic [4:0]      r_stable_d;
  logic [4:0]      w_edge;
  logic [DB_W-1:0] r_dbc [5];

  assign w_raw = {restock, cancel, coin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 5; i++) r_dbc[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 5; i++) begin
        // a new level must persist DEBOUNCE_CYCLES cycles to be taken
        if (r_sync2[i] != r_stable[i]) begin
          if (r_dbc[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable[i] <= r_sync2[i];
            r_dbc[i]    <= '0;
          end else begin
            r_dbc[i] <= r_dbc[i] + DB_W'(1);
          end
        end else begin
          r_dbc[i] <= '0;
        end
      end
    end
  end

  assign w_edge = r_stable & ~r_stable_d;

  logic [2:0]         w_coin_ev;
  logic               w_cancel_ev;
  logic               w_restock_ev;
  logic               w_any;
  logic               w_multi;
  logic [AMT_W-1:0]   w_coin_val;
  logic [AMT_W:0]     w_sum;
  logic               w_open;
  logic               w_accept;
  logic               w_empty;

  logic [2:0]         r_state;
  logic [AMT_W-1:0]   r_credit;
  logic [STOCK_W-1:0] r_stock;
  logic               r_news;
  logic               r_pulse;
  logic               r_reject;
  logic [DISP_W-1:0]  r_disp;
  logic [GAP_W-1:0]   r_gap;

  assign w_coin_ev    = w_edge[2:0];
  assign w_cancel_ev  = w_edge[3];
  assign w_restock_ev = w_edge[4];
  assign w_any        = |w_coin_ev;
  assign w_multi      = (w_coin_ev & (w_coin_ev - 3'd1)) != 3'd0;

  always_comb begin
    w_coin_val = '0;
    if (w_coin_ev[0])      w_coin_val = L_C0;
    else if (w_coin_ev[1]) w_coin_val = L_C1;
    else if (w_coin_ev[2]) w_coin_val = L_C2;
  end

  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};

  // ACCUM stops taking coins once a sale is due or a cancel is seen
  assign w_open = (r_state == S_IDLE) ||
                  ((r_state == S_ACCUM) && !w_cancel_ev &&
                   (r_credit < L_PRICE));
  assign w_accept = w_any && w_open && (w_sum <= L_MAX);

  // a coincident restock refills the shelf, so do not park in SOLDOUT
  assign w_empty = (r_stock == '0) && !w_restock_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_stock  <= STOCK_W'(STOCK_INIT);
      r_news   <= 1'b0;
      r_pulse  <= 1'b0;
      r_reject <= 1'b0;
      r_disp   <= '0;
      r_gap    <= '0;
    end else begin
      r_pulse  <= 1'b0;
      r_reject <= w_any && (!w_accept || w_multi);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_credit <= w_sum[AMT_W-1:0];
            r_state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_cancel_ev) begin
            r_state <= S_REFUND;
            r_gap   <= '0;
          end else if (r_credit >= L_PRICE) begin
            r_state  <= S_VEND;
            r_credit <= r_credit - L_PRICE;
            r_news   <= 1'b1;
            r_disp   <= '0;
            if (r_stock != '0) r_stock <= r_stock - STOCK_W'(1);
          end else if (w_accept) begin
            r_credit <= w_sum[AMT_W-1:0];
          end
        end
        S_VEND: begin
          if (r_disp == DISP_W'(DISPLAY_CYCLES - 1)) begin
            r_news <= 1'b0;
            r_disp <= '0;
            r_gap  <= '0;
            if (r_credit != '0) r_state <= S_CHANGE;
            else if (w_empty)   r_state <= S_SOLDOUT;
            else                r_state <= S_IDLE;
          end else begin
            r_disp <= r_disp + DISP_W'(1);
          end
        end
        S_CHANGE, S_REFUND: begin
          // gap of 0 on entry gives the first pulse straight away
          if (r_credit == '0) begin
            r_state <= w_empty ? S_SOLDOUT : S_IDLE;
          end else if (r_gap == '0) begin
            r_pulse  <= 1'b1;
            r_credit <= r_credit - L_UNIT;
            r_gap    <= GAP_W'(CHANGE_GAP - 1);
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        S_SOLDOUT: begin
          if (w_restock_ev) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_restock_ev) r_stock <= STOCK_W'(STOCK_INIT);
    end
  end

  assign newspaper    = r_news;
  assign credit       = r_credit;
  assign change_pulse = r_pulse;
  assign coin_reject  = r_reject;
  assign stock        = r_stock;
  assign sold_out     = (r_stock == '0);

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: step table of inputs and expected
// output events, scoreboard queue popped by an output-event monitor.
module tb_vending_machine_change;

  localparam int K_REJ   = 0;
  localparam int K_CRED  = 1;
  localparam int K_VEND  = 2;
  localparam int K_PULSE = 3;
  localparam int K_OFF   = 4;
  localparam int K_STK   = 5;

  typedef struct packed {
    int kind;
    int cred;
    int stk;
    int so;
    int dt;
  } ev_t;

  typedef struct packed {
    logic [2:0] coin;
    logic       cancel;
    logic       restock;
    int         first;
    int         n;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] coin = 3'b000;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       newspaper;
  logic [5:0] credit;
  logic       change_pulse;
  logic       coin_reject;
  logic [3:0] stock;
  logic       sold_out;

  always #5 clk = ~clk;

  vending_machine_change #(
    .DEBOUNCE_CYCLES(4),
    .DISPLAY_CYCLES(20),
    .CHANGE_GAP(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin(coin),
    .cancel(cancel),
    .restock(restock),
    .newspaper(newspaper),
    .credit(credit),
    .change_pulse(change_pulse),
    .coin_reject(coin_reject),
    .stock(stock),
    .sold_out(sold_out)
  );

  ev_t   evt [0:127];
  step_t stp [0:31];
  ev_t   q [$];
  int    ne = 0;
  int    ns = 0;
  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  int    rise_cyc = 0;
  int    pulses = 0;
  bit    mon_en = 1'b0;
  logic [5:0] p_cred;
  logic [3:0] p_stk;
  logic       p_news;

  function automatic ev_t mk(int k, int c, int s, int so, int dt);
    ev_t e;
    e.kind = k;
    e.cred = c;
    e.stk  = s;
    e.so   = so;
    e.dt   = dt;
    return e;
  endfunction

  task automatic observe(ev_t a);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected event: kind=%0d credit=%0d stock=%0d",
               a.kind, a.cred, a.stk);
    end else begin
      e = q.pop_front();
      if (a.kind != e.kind || a.cred != e.cred || a.stk != e.stk ||
          a.so != e.so || (e.dt >= 0 && a.dt != e.dt)) begin
        fails++;
        $display("FAIL event: got k=%0d cr=%0d st=%0d so=%0d dt=%0d, want k=%0d cr=%0d st=%0d so=%0d dt=%0d",
                 a.kind, a.cred, a.stk, a.so, a.dt,
                 e.kind, e.cred, e.stk, e.so, e.dt);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (change_pulse) pulses++;
      if (coin_reject)
        observe(mk(K_REJ, int'(credit), int'(stock), int'(sold_out), -1));
      if (newspaper && !p_news) begin
        observe(mk(K_VEND, int'(credit), int'(stock), int'(sold_out),
                   cyc - last_cyc));
        last_cyc = cyc;
        rise_cyc = cyc;
      end else if (change_pulse) begin
        observe(mk(K_PULSE, int'(credit), int'(stock), int'(sold_out),
                   cyc - last_cyc));
        last_cyc = cyc;
      end else if (credit != p_cred) begin
        observe(mk(K_CRED, int'(credit), int'(stock), int'(sold_out), -1));
        last_cyc = cyc;
      end
      if (!newspaper && p_news) begin
        observe(mk(K_OFF, int'(credit), int'(stock), int'(sold_out),
                   cyc - rise_cyc));
        last_cyc = cyc;
      end
      if (stock != p_stk && !(newspaper && !p_news)) begin
        observe(mk(K_STK, int'(credit), int'(stock), int'(sold_out), -1));
        last_cyc = cyc;
      end
    end
    p_cred = credit;
    p_stk  = stock;
    p_news = newspaper;
  end

  task automatic step(logic [2:0] c, logic cn, logic rs);
    stp[ns].coin    = c;
    stp[ns].cancel  = cn;
    stp[ns].restock = rs;
    stp[ns].first   = ne;
    stp[ns].n       = 0;
    ns++;
  endtask

  task automatic ex(int k, int c, int s, int so, int dt);
    evt[ne] = mk(k, c, s, so, dt);
    ne++;
    stp[ns-1].n++;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press(logic [2:0] c, logic cn, logic rs);
    coin = c;
    cancel = cn;
    restock = rs;
    repeat (8) @(posedge clk);
    #1;
    coin = 3'b000;
    cancel = 1'b0;
    restock = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events not seen", nm, q.size());
      q.delete();
    end
  endtask

  task automatic run(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      for (int j = stp[i].first; j < stp[i].first + stp[i].n; j++)
        q.push_back(evt[j]);
      press(stp[i].coin, stp[i].cancel, stp[i].restock);
      drain($sformatf("step%0d", i));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pb;
    int t;
    // 0: coin 5
    step(3'b001, 0, 0); ex(K_CRED, 5, 8, 0, -1);
    // 1: coin 10 -> sale, no change
    step(3'b010, 0, 0); ex(K_CRED, 15, 8, 0, -1);
    ex(K_VEND, 0, 7, 0, 1); ex(K_OFF, 0, 7, 0, 20);
    // 2,3: coin 10 then 15 -> sale with 10 change
    step(3'b010, 0, 0); ex(K_CRED, 10, 7, 0, -1);
    step(3'b100, 0, 0); ex(K_CRED, 25, 7, 0, -1);
    ex(K_VEND, 10, 6, 0, 1); ex(K_OFF, 10, 6, 0, 20);
    ex(K_PULSE, 5, 6, 0, 1); ex(K_PULSE, 0, 6, 0, 8);
    // 4,5: coin 10 then cancel -> refund
    step(3'b010, 0, 0); ex(K_CRED, 10, 6, 0, -1);
    step(3'b000, 1, 0); ex(K_PULSE, 5, 6, 0, -1);
    ex(K_PULSE, 0, 6, 0, 8);
    // 6: cancel in IDLE ignored
    step(3'b000, 1, 0);
    // 7: coins 5 and 10 together
    step(3'b011, 0, 0); ex(K_REJ, 5, 6, 0, -1); ex(K_CRED, 5, 6, 0, -1);
    // 8: cancel with coin in ACCUM
    step(3'b010, 1, 0); ex(K_REJ, 5, 6, 0, -1); ex(K_PULSE, 0, 6, 0, -1);
    // 9..13: five sales down to empty
    for (int s = 5; s >= 1; s--) begin
      step(3'b100, 0, 0);
      ex(K_CRED, 15, s, 0, -1);
      ex(K_VEND, 0, s - 1, (s == 1) ? 1 : 0, 1);
      ex(K_OFF, 0, s - 1, (s == 1) ? 1 : 0, 20);
    end
    // 14,15: sold out coin and cancel
    step(3'b001, 0, 0); ex(K_REJ, 0, 0, 1, -1);
    step(3'b000, 1, 0);
    // 16: restock
    step(3'b000, 0, 1); ex(K_STK, 0, 8, 0, -1);
    // 17,18: back in service
    step(3'b001, 0, 0); ex(K_CRED, 5, 8, 0, -1);
    step(3'b010, 0, 0); ex(K_CRED, 15, 8, 0, -1);
    ex(K_VEND, 0, 7, 0, 1); ex(K_OFF, 0, 7, 0, 20);
    // 19: credit 10 ahead of the reset sequence
    step(3'b010, 0, 0); ex(K_CRED, 10, 7, 0, -1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset credit", int'(credit), 0);
    chk("reset stock", int'(stock), 8);
    chk("reset newspaper", int'(newspaper), 0);
    chk("reset change_pulse", int'(change_pulse), 0);
    chk("reset coin_reject", int'(coin_reject), 0);
    chk("reset sold_out", int'(sold_out), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(0, 9);

    // coin arriving while the LED is on
    q.push_back(mk(K_CRED, 15, 6, 0, -1));
    q.push_back(mk(K_VEND, 0, 5, 0, 1));
    q.push_back(mk(K_REJ, 0, 5, 0, -1));
    q.push_back(mk(K_OFF, 0, 5, 0, 20));
    coin = 3'b100;
    t = 0;
    while (!newspaper && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("vend started", int'(newspaper), 1);
    coin = 3'b001;
    repeat (8) @(posedge clk);
    #1;
    coin = 3'b000;
    repeat (8) @(posedge clk);
    #1;
    drain("coin in vend");

    run(9, 14);
    chk("empty stock", int'(stock), 0);
    chk("empty sold_out", int'(sold_out), 1);
    run(14, 20);
    chk("restocked sold_out", int'(sold_out), 0);

    // reset after the first change pulse
    q.push_back(mk(K_CRED, 25, 7, 0, -1));
    q.push_back(mk(K_VEND, 10, 6, 0, 1));
    q.push_back(mk(K_OFF, 10, 6, 0, 20));
    q.push_back(mk(K_PULSE, 5, 6, 0, 1));
    press(3'b100, 0, 0);
    drain("change before reset");
    q.push_back(mk(K_CRED, 0, 8, 0, -1));
    q.push_back(mk(K_STK, 0, 8, 0, -1));
    pb = pulses;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid reset credit", int'(credit), 0);
    chk("mid reset stock", int'(stock), 8);
    chk("mid reset newspaper", int'(newspaper), 0);
    chk("mid reset coin_reject", int'(coin_reject), 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("pulses after reset", pulses - pb, 0);
    chk("credit after reset", int'(credit), 0);
    drain("reset events");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/vending_machine_change.md
VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 SHALL have parameter PRICE, default 15, item price in rupees.
REQ-002 SHALL have parameter COIN_UNIT, default 5, change granularity in rupees; PRICE and all coin values are multiples of it.
REQ-003 SHALL have parameters COIN0_VAL / COIN1_VAL / COIN2_VAL, defaults 5 / 10 / 15, the rupee value of each coin input.
REQ-004 SHALL have parameter MAX_CREDIT, default 30, the credit ceiling in rupees.
REQ-005 SHALL have parameter AMT_W, default 6, the credit width; 2^AMT_W > MAX_CREDIT.
REQ-006 SHALL have parameters STOCK_INIT and STOCK_W, defaults 8 and 4, the initial item count and its width.
REQ-007 SHALL have parameters DEBOUNCE_CYCLES, DISPLAY_CYCLES and CHANGE_GAP, defaults 1_000_000, 200_000_000 and 50_000_000: stable time, dispense LED time and change-pulse spacing, all in clk cycles.
REQ-008 SHALL have port clk, input, 1 bit, 100 MHz clock.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-010 SHALL have port coin, input, 3 bits, raw coin switches; bit i carries COINi_VAL.
REQ-011 SHALL have ports cancel and restock, inputs, 1 bit each, raw buttons.
REQ-012 SHALL have port newspaper, output, 1 bit, dispense LED.
REQ-013 SHALL have port credit, output, AMT_W bits, current credit or pending change in rupees.
REQ-014 SHALL have ports change_pulse and coin_reject, outputs, 1 bit each, single-cycle event pulses.
REQ-015 SHALL have ports stock (output, STOCK_W bits, items remaining) and sold_out (output, 1 bit, high when stock is 0).

Function
REQ-016 SHALL pass every raw input through a 2-FF synchroniser and a DEBOUNCE_CYCLES stability filter, then act only on its rising edge (1-cycle event).
REQ-017 SHALL implement states IDLE, ACCUM, VEND, CHANGE, REFUND and SOLDOUT.
REQ-018 SHALL register a coin edge seen in cycle t into credit at t+1 when in IDLE or ACCUM; IDLE moves to ACCUM on the first credit.
REQ-019 SHALL on simultaneous coin edges accept only the lowest index and pulse coin_reject once for the rest.
REQ-020 SHALL reject any coin that would push credit past MAX_CREDIT, and any coin seen in VEND, CHANGE, REFUND or SOLDOUT: credit unchanged, coin_reject pulsed.
REQ-021 SHALL when credit >= PRICE: go to VEND on the next cycle, decrement stock once on entry, load credit with credit-PRICE, and hold newspaper high for exactly DISPLAY_CYCLES cycles.
REQ-022 SHALL leave VEND for CHANGE if credit > 0, else for SOLDOUT if stock == 0, else for IDLE.
REQ-023 SHALL in CHANGE and REFUND emit one change_pulse per COIN_UNIT: first pulse on the cycle after entry, then every CHANGE_GAP cycles, credit dropping by COIN_UNIT with each pulse.
REQ-024 SHALL exit CHANGE/REFUND on the cycle after credit reaches 0, to SOLDOUT if stock == 0, else to IDLE.
REQ-025 SHALL on a cancel edge in ACCUM go to REFUND; cancel in any other state is ignored.
REQ-026 SHALL when cancel and a coin edge coincide in ACCUM give cancel priority and reject the coin.
REQ-027 SHALL on a restock edge set stock = STOCK_INIT in any state; in SOLDOUT move to IDLE on the next cycle.
REQ-028 SHALL drive sold_out combinationally from stock == 0.
REQ-029 SHALL size counters to hold DISPLAY_CYCLES, CHANGE_GAP and DEBOUNCE_CYCLES without wrap.

Reset
REQ-030 SHALL, on reset assertion, immediately force state IDLE, credit 0, newspaper 0, change_pulse 0, coin_reject 0 and stock STOCK_INIT, and clear all debounce, edge, display and gap counters.
REQ-031 SHALL discard pending credit or change on reset mid-operation and emit no further pulses.
REQ-032 SHALL accept coins only after reset deasserts and inputs pass the full synchroniser and debounce path.

Verification (DEBOUNCE_CYCLES=4, DISPLAY_CYCLES=20, CHANGE_GAP=8, other parameters at default)
REQ-033 SHALL cover coin 5 then 10: credit 5, then 15; then VEND, newspaper high 20 cycles, stock 8->7, credit 0, no change_pulse, back to IDLE.
REQ-034 SHALL cover coin 10 then 15: VEND leaves credit 10; then 2 change_pulses 8 cycles apart, credit 10->5->0, then IDLE.
REQ-035 SHALL cover coin 10 then cancel: REFUND gives 2 change_pulses, credit 0, stock unchanged, newspaper stays 0.
REQ-036 SHALL cover coin 5 and 10 edges in the same cycle: credit 5 and one coin_reject; a coin during VEND is rejected with credit unchanged.
REQ-037 SHALL cover 8 vends: stock 0 and sold_out 1; a further coin gives coin_reject; restock gives stock 8, sold_out 0, state IDLE.
REQ-038 SHALL cover reset asserted in CHANGE after 1 pulse: credit 0, no further change_pulse, stock kept at STOCK_INIT.
